// File: rtl/updown_seq_ctrl.sv
// Up/down sweep sequencer: counts lo->hi, dwells at each end, single or continuous.
// Optional pause input enabled by defining UDSEQ_PAUSE_EN.
module updown_seq_ctrl #(
   parameter int unsigned WIDTH   = 3,
   parameter int unsigned DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
`ifdef UDSEQ_PAUSE_EN
   input  logic               pause,
`endif
   input  logic               stop,
   input  logic [WIDTH-1:0]   lo,
   input  logic [WIDTH-1:0]   hi,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               mode,
   output logic [WIDTH-1:0]   cnt,
   output logic               dir,
   output logic               busy,
   output logic               done,
   output logic               err
);

   typedef enum logic [2:0] {IDLE, UP, TOP_HOLD, DOWN, BOT_HOLD} state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   cnt_n, lo_q, lo_n, hi_q, hi_n;
   logic [DWELL_W-1:0] dcnt, dcnt_n, dwell_q, dwell_n;
   logic               mode_q, mode_n, dir_n, busy_n, done_n, err_n;
   logic [WIDTH-1:0]   cnt_inc, cnt_dec, hi_m1, lo_p1;
   logic               pause_c;

`ifdef UDSEQ_PAUSE_EN
   assign pause_c = pause;
`else
   assign pause_c = 1'b0;
`endif

   // Bounds never wrap while busy since cnt stays within [lo, hi]
   assign cnt_inc = cnt + WIDTH'(1);
   assign cnt_dec = cnt - WIDTH'(1);
   assign hi_m1   = hi_q - WIDTH'(1);
   assign lo_p1   = lo_q + WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         dcnt    <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         dwell_q <= '0;
         mode_q  <= 1'b0;
         dir     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         dcnt    <= dcnt_n;
         lo_q    <= lo_n;
         hi_q    <= hi_n;
         dwell_q <= dwell_n;
         mode_q  <= mode_n;
         dir     <= dir_n;
         busy    <= busy_n;
         done    <= done_n;
         err     <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dcnt_n  = dcnt;
      lo_n    = lo_q;
      hi_n    = hi_q;
      dwell_n = dwell_q;
      mode_n  = mode_q;
      done_n  = 1'b0;
      err_n   = 1'b0;

      case (state)
         IDLE: begin
            if (!stop && start) begin
               if (lo < hi) begin
                  lo_n    = lo;
                  hi_n    = hi;
                  dwell_n = dwell;
                  mode_n  = mode;
                  cnt_n   = lo;
                  state_n = UP;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         UP: begin
            cnt_n = cnt_inc;
            if (cnt_inc == hi_q) begin
               state_n = TOP_HOLD;
               dcnt_n  = dwell_q;
            end
         end
         TOP_HOLD: begin
            if (dcnt == '0) begin
               cnt_n = hi_m1;
               if (hi_m1 == lo_q) begin
                  state_n = BOT_HOLD;
                  dcnt_n  = dwell_q;
               end else begin
                  state_n = DOWN;
               end
            end else begin
               dcnt_n = dcnt - DWELL_W'(1);
            end
         end
         DOWN: begin
            cnt_n = cnt_dec;
            if (cnt_dec == lo_q) begin
               state_n = BOT_HOLD;
               dcnt_n  = dwell_q;
            end
         end
         BOT_HOLD: begin
            if (dcnt == '0) begin
               if (mode_q) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  cnt_n = lo_p1;
                  if (lo_p1 == hi_q) begin
                     state_n = TOP_HOLD;
                     dcnt_n  = dwell_q;
                  end else begin
                     state_n = UP;
                  end
               end
            end else begin
               dcnt_n = dcnt - DWELL_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // Abort beats any natural transition; pause freezes everything in place
      if (state != IDLE) begin
         if (stop) begin
            state_n = IDLE;
            cnt_n   = cnt;
            dcnt_n  = dcnt;
            done_n  = 1'b0;
         end else if (pause_c) begin
            state_n = state;
            cnt_n   = cnt;
            dcnt_n  = dcnt;
            done_n  = 1'b0;
         end
      end

      dir_n  = (state_n == UP) || (state_n == TOP_HOLD);
      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Testbench for updown_seq_ctrl: directed table, hand sequences and randomized run vs sweep model.
module tb_updown_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0, pause = 1'b0;
   logic [2:0] lo = '0, hi = '0;
   logic [3:0] dwell = '0;
   logic [2:0] cnt;
   logic       dir, busy, done, err;

   int checks = 0;
   int errors = 0;

   updown_seq_ctrl dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
`ifdef UDSEQ_PAUSE_EN
      .pause (pause),
`endif
      .stop  (stop),
      .lo    (lo),
      .hi    (hi),
      .dwell (dwell),
      .mode  (mode),
      .cnt   (cnt),
      .dir   (dir),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   // Reference model: each launch expands into the list of (cnt, dir) values to show
   typedef struct { int c; bit d; } exp_t;
   exp_t q[$];
   int   m_cnt = 0, m_lo = 0, m_hi = 0, m_dw = 0;
   bit   m_dir = 0, m_busy = 0, m_done = 0, m_err = 0, m_mode = 0;

   function automatic void push_period();
      for (int v = m_lo + 1; v < m_hi; v++) q.push_back('{v, 1'b1});
      for (int i = 0; i <= m_dw; i++) q.push_back('{m_hi, 1'b1});
      for (int v = m_hi - 1; v > m_lo; v--) q.push_back('{v, 1'b0});
      for (int i = 0; i <= m_dw; i++) q.push_back('{m_lo, 1'b0});
   endfunction

   function automatic void show_next();
      exp_t e;
      e = q.pop_front();
      m_cnt = e.c;
      m_dir = e.d;
   endfunction

   function automatic void model_step();
      m_done = 0;
      m_err  = 0;
      if (rst) begin
         m_cnt = 0; m_dir = 0; m_busy = 0;
         q.delete();
      end else if (m_busy) begin
         if (stop) begin
            m_busy = 0; m_dir = 0;
            q.delete();
         end else if (!pause) begin
            if (q.size() == 0 && !m_mode) push_period();
            if (q.size() == 0) begin
               m_busy = 0; m_dir = 0; m_done = 1;
            end else begin
               show_next();
            end
         end
      end else if (start && !stop) begin
         if (int'(lo) < int'(hi)) begin
            m_lo = int'(lo); m_hi = int'(hi); m_dw = int'(dwell); m_mode = mode;
            q.delete();
            q.push_back('{m_lo, 1'b1});
            push_period();
            m_busy = 1;
            show_next();
         end else begin
            m_err = 1;
         end
      end
   endfunction

   task automatic chk(input string name, input int e_cnt, input bit e_dir, input bit e_busy,
                      input bit e_done, input bit e_err);
      checks++;
      if (int'(cnt) != e_cnt || dir !== e_dir || busy !== e_busy || done !== e_done || err !== e_err) begin
         errors++;
         $display("FAIL %s: got cnt=%0d dir=%b busy=%b done=%b err=%b, expected cnt=%0d dir=%b busy=%b done=%b err=%b",
                  name, cnt, dir, busy, done, err, e_cnt, e_dir, e_busy, e_done, e_err);
      end
   endtask

   // One clock: advance model with the inputs present at the edge, then compare
   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      chk("model", m_cnt, m_dir, m_busy, m_done, m_err);
   endtask

   task automatic set_in(input bit s, input bit p, input int l, input int h, input int d, input bit m);
      start = s; stop = p; lo = 3'(l); hi = 3'(h); dwell = 4'(d); mode = m;
   endtask

   typedef struct {
      bit rst, start, stop; int lo, hi, dw; bit mode;
      int e_cnt; bit e_dir, e_busy, e_done, e_err;
   } vec_t;
   vec_t tbl[13];

   int exp_single[13] = '{0,1,2,3,4,5,6,5,4,3,2,1,0};
   int exp_cont[20]   = '{2,3,4,5,5,5,4,3,2,2,2,3,4,5,5,5,4,3,2,2};
   bit dir_cont[20]   = '{1,1,1,1,1,1,0,0,0,0,0,1,1,1,1,1,0,0,0,0};

   initial begin
      tbl[0]  = '{1,0,0, 0,0,0,0, 0,0,0,0,0};
      tbl[1]  = '{1,0,0, 0,0,0,0, 0,0,0,0,0};
      tbl[2]  = '{0,0,0, 0,0,0,0, 0,0,0,0,0};
      tbl[3]  = '{0,1,0, 4,4,0,1, 0,0,0,0,1};
      tbl[4]  = '{0,0,0, 4,4,0,1, 0,0,0,0,0};
      tbl[5]  = '{0,1,0, 3,4,0,0, 3,1,1,0,0};
      tbl[6]  = '{0,0,0, 0,7,3,1, 4,1,1,0,0};
      tbl[7]  = '{0,1,0, 0,7,3,1, 3,0,1,0,0};
      tbl[8]  = '{0,0,0, 3,4,0,0, 4,1,1,0,0};
      tbl[9]  = '{0,0,1, 3,4,0,0, 4,0,0,0,0};
      tbl[10] = '{0,1,1, 0,6,0,1, 4,0,0,0,0};
      tbl[11] = '{0,1,0, 6,1,0,1, 4,0,0,0,1};
      tbl[12] = '{0,0,0, 6,1,0,1, 4,0,0,0,0};

      for (int i = 0; i < 13; i++) begin
         rst = tbl[i].rst;
         set_in(tbl[i].start, tbl[i].stop, tbl[i].lo, tbl[i].hi, tbl[i].dw, tbl[i].mode);
         tick();
         chk($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_dir, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err);
      end
      rst = 0;

      // Single sweep 0..6..0, no dwell
      set_in(1, 0, 0, 6, 0, 1);
      for (int i = 0; i < 13; i++) begin
         tick();
         start = 0;
         chk($sformatf("single%0d", i), exp_single[i], (i < 7), 1, 0, 0);
      end
      tick();
      chk("single_done", 0, 0, 0, 1, 0);
      tick();
      chk("single_after", 0, 0, 0, 0, 0);

      // Continuous 2..5 with dwell 2
      set_in(1, 0, 2, 5, 2, 0);
      for (int i = 0; i < 20; i++) begin
         tick();
         start = 0;
         chk($sformatf("cont%0d", i), exp_cont[i], dir_cont[i], 1, 0, 0);
      end
      stop = 1;
      tick();
      chk("cont_stop", 2, 0, 0, 0, 0);
      stop = 0;

      // Abort at cnt=3 while counting up, with a simultaneous start
      set_in(1, 0, 0, 6, 0, 1);
      tick();
      start = 0;
      tick(); tick(); tick();
      chk("abort_pre", 3, 1, 1, 0, 0);
      start = 1; stop = 1;
      tick();
      chk("abort", 3, 0, 0, 0, 0);
      start = 0; stop = 0;
      tick();
      chk("abort_hold", 3, 0, 0, 0, 0);

      // Reset mid-sweep
      set_in(1, 0, 1, 7, 1, 0);
      tick();
      start = 0;
      tick(); tick();
      rst = 1;
      tick();
      chk("rst_mid", 0, 0, 0, 0, 0);
      rst = 0;

`ifdef UDSEQ_PAUSE_EN
      set_in(1, 0, 0, 6, 0, 1);
      tick();
      start = 0;
      for (int i = 0; i < 4; i++) tick();
      pause = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("pause%0d", i), 4, 1, 1, 0, 0);
      end
      pause = 0;
      tick();
      chk("resume5", 5, 1, 1, 0, 0);
      tick();
      chk("resume6", 6, 1, 1, 0, 0);
      stop = 1;
      tick();
      stop = 0;
`endif

      // Randomized run against the model
      for (int i = 0; i < 4000; i++) begin
         rst   = ($urandom_range(299) == 0);
         start = ($urandom_range(3) == 0);
         stop  = ($urandom_range(59) == 0);
         lo    = 3'($urandom);
         hi    = 3'($urandom);
         dwell = ($urandom_range(7) == 0) ? 4'($urandom) : 4'($urandom_range(2));
         mode  = 1'($urandom);
`ifdef UDSEQ_PAUSE_EN
         pause = ($urandom_range(7) == 0);
`endif
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
